// File: rtl/life_gen_ctrl.sv
// life_gen_ctrl: sequences Game of Life (B3/S23) generations on an X*Y board.
// Owns the circulating board shift register (data_o) and the cell counter
// (cnt_o) that drive life_neighbour, folds the nine neighbourhood bits into
// the next-generation cell and commits a whole generation at a time.
//
// Request contract: load_i and start_i are single-cycle requests that are
// accepted only while busy_o is low (busy_o is the inverted ready). A request
// presented while busy_o is high is dropped, never queued, and has no side
// effect. When both arrive in the same idle cycle, load_i wins and start_i is
// dropped. stop_i is only meaningful while busy_o is high.
module life_gen_ctrl #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3,
  parameter int GW    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [X*Y-1:0]         load_data_i,
  input  logic                   start_i,
  input  logic [GW-1:0]          num_gens_i,
  input  logic                   stop_i,
  output logic [X*Y-1:0]         data_o,
  output logic [LOG2X+LOG2Y-1:0] cnt_o,
  input  logic                   nb_c_i,
  input  logic                   nb_l_i,
  input  logic                   nb_r_i,
  input  logic                   nb_u_i,
  input  logic                   nb_d_i,
  input  logic                   nb_lu_i,
  input  logic                   nb_ld_i,
  input  logic                   nb_ru_i,
  input  logic                   nb_rd_i,
  output logic [X*Y-1:0]         board_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   stable_o,
  output logic [LOG2X+LOG2Y:0]   pop_o,
  output logic [GW-1:0]          gen_count_o,
  output logic [1:0]             state_o
);

  localparam int N  = X * Y;
  localparam int CW = LOG2X + LOG2Y;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  state_e          state_q,     state_d;
  logic [N-1:0]    data_q,      data_d;
  logic [N-1:0]    next_sr_q,   next_sr_d;
  logic [N-1:0]    board_q,     board_d;
  logic [CW-1:0]   cnt_q,       cnt_d;
  logic [CW:0]     pop_q,       pop_d;
  logic [CW:0]     pop_acc_q,   pop_acc_d;
  logic [GW-1:0]   gen_count_q, gen_count_d;
  logic [GW-1:0]   gens_left_q, gens_left_d;
  logic            stop_seen_q, stop_seen_d;
  logic            stable_q,    stable_d;
  logic            done_q,      done_d;

  logic [3:0]      nb_sum;
  logic            cell_new;
  logic            last_cell;
  logic            board_same;
  logic            finish_run;
  logic [CW:0]     load_pop;

  // Live-cell count of an arbitrary board, used when a new board is loaded.
  function automatic logic [CW:0] popcount(input logic [N-1:0] v);
    logic [CW:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      s = s + {{CW{1'b0}}, v[i]};
    end
    return s;
  endfunction

  // Neighbour sum, B3/S23 rule and the end-of-generation decision.
  always_comb begin
    nb_sum     = 4'(nb_l_i)  + 4'(nb_r_i)  + 4'(nb_u_i)  + 4'(nb_d_i) +
                 4'(nb_lu_i) + 4'(nb_ld_i) + 4'(nb_ru_i) + 4'(nb_rd_i);
    cell_new   = (nb_sum == 4'd3) | (nb_c_i & (nb_sum == 4'd2));
    last_cell  = (cnt_q == CW'(N - 1));
    board_same = (next_sr_q == board_q);
    // stop_i in the commit cycle itself also counts as seen during the run.
    finish_run = (gens_left_q == GW'(1)) | stop_seen_q | stop_i | board_same;
    load_pop   = popcount(load_data_i);
  end

  // Next-state and datapath updates; every register holds unless its state acts.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    next_sr_d   = next_sr_q;
    board_d     = board_q;
    cnt_d       = cnt_q;
    pop_d       = pop_q;
    pop_acc_d   = pop_acc_q;
    gen_count_d = gen_count_q;
    gens_left_d = gens_left_q;
    stop_seen_d = stop_seen_q;
    stable_d    = stable_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_i) begin
          // data is kept rotated so that the cell at index cnt sits in the MSB.
          board_d     = load_data_i;
          data_d      = {load_data_i[0], load_data_i[N-1:1]};
          gen_count_d = '0;
          stable_d    = 1'b0;
          pop_d       = load_pop;
        end else if (start_i) begin
          gens_left_d = (num_gens_i == '0) ? GW'(1) : num_gens_i;
          cnt_d       = '0;
          next_sr_d   = '0;
          pop_acc_d   = '0;
          stop_seen_d = 1'b0;
          state_d     = S_SCAN;
        end
      end

      S_SCAN: begin
        // After N shifts the cell computed at cnt=0 lands in bit 0.
        next_sr_d = {cell_new, next_sr_q[N-1:1]};
        pop_acc_d = pop_acc_q + {{CW{1'b0}}, cell_new};
        data_d    = {data_q[0], data_q[N-1:1]};
        cnt_d     = cnt_q + CW'(1);
        if (stop_i) begin
          stop_seen_d = 1'b1;
        end
        if (last_cell) begin
          state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        board_d     = next_sr_q;
        data_d      = {next_sr_q[0], next_sr_q[N-1:1]};
        cnt_d       = '0;
        stable_d    = board_same;
        pop_d       = pop_acc_q;
        gen_count_d = gen_count_q + GW'(1);
        gens_left_d = gens_left_q - GW'(1);
        if (finish_run) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          stop_seen_d = 1'b0;
        end else begin
          state_d   = S_SCAN;
          next_sr_d = '0;
          pop_acc_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any run immediately without committing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      next_sr_q   <= '0;
      board_q     <= '0;
      cnt_q       <= '0;
      pop_q       <= '0;
      pop_acc_q   <= '0;
      gen_count_q <= '0;
      gens_left_q <= '0;
      stop_seen_q <= 1'b0;
      stable_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      next_sr_q   <= next_sr_d;
      board_q     <= board_d;
      cnt_q       <= cnt_d;
      pop_q       <= pop_d;
      pop_acc_q   <= pop_acc_d;
      gen_count_q <= gen_count_d;
      gens_left_q <= gens_left_d;
      stop_seen_q <= stop_seen_d;
      stable_q    <= stable_d;
      done_q      <= done_d;
    end
  end

  // Output mapping; busy is a pure decode of the state.
  always_comb begin
    data_o      = data_q;
    cnt_o       = cnt_q;
    board_o     = board_q;
    busy_o      = (state_q != S_IDLE);
    done_o      = done_q;
    stable_o    = stable_q;
    pop_o       = pop_q;
    gen_count_o = gen_count_q;
    state_o     = state_q;
  end

endmodule

// File: tb/tb_life_gen_ctrl.sv
// tb_life_gen_ctrl: bench for life_gen_ctrl. Emulates life_neighbour from the
// data/cnt outputs and checks boards against a 2-D Game of Life model.
module tb_life_gen_ctrl;

  localparam int X  = 8;
  localparam int Y  = 8;
  localparam int N  = X * Y;
  localparam int CW = 6;
  localparam int GW = 16;
  localparam int GEN_CYCLES = N + 1;

  logic          clk, rst, load, start, stop;
  logic [N-1:0]  load_data;
  logic [GW-1:0] num_gens;
  logic [N-1:0]  data;
  logic [CW-1:0] cnt;
  logic          nb_c, nb_l, nb_r, nb_u, nb_d, nb_lu, nb_ld, nb_ru, nb_rd;
  logic [N-1:0]  board;
  logic          busy, done, stable;
  logic [CW:0]   pop;
  logic [GW-1:0] gen_count;
  logic [1:0]    state;

  int tests;
  int fails;
  logic [N-1:0] exp_q[$];

  life_gen_ctrl #(.X(X), .Y(Y), .LOG2X(3), .LOG2Y(3), .GW(GW)) dut (
    .clk_i(clk), .rst_i(rst), .load_i(load), .load_data_i(load_data),
    .start_i(start), .num_gens_i(num_gens), .stop_i(stop),
    .data_o(data), .cnt_o(cnt),
    .nb_c_i(nb_c), .nb_l_i(nb_l), .nb_r_i(nb_r), .nb_u_i(nb_u), .nb_d_i(nb_d),
    .nb_lu_i(nb_lu), .nb_ld_i(nb_ld), .nb_ru_i(nb_ru), .nb_rd_i(nb_rd),
    .board_o(board), .busy_o(busy), .done_o(done), .stable_o(stable),
    .pop_o(pop), .gen_count_o(gen_count), .state_o(state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- life_neighbour stand-in ----------------
  // Cell k sits at bit (N-1+k-cnt) mod N of data; off-board cells read as 0.
  function automatic logic nb_of(input logic [N-1:0] d, input logic [CW-1:0] c,
                                 input int dx, input int dy);
    int x, y, k;
    x = int'(c) % X + dx;
    y = int'(c) / X + dy;
    if (x < 0 || x >= X || y < 0 || y >= Y) return 1'b0;
    k = y * X + x;
    return d[(N - 1 + k - int'(c)) % N];
  endfunction

  assign nb_c  = nb_of(data, cnt,  0,  0);
  assign nb_l  = nb_of(data, cnt, -1,  0);
  assign nb_r  = nb_of(data, cnt,  1,  0);
  assign nb_u  = nb_of(data, cnt,  0, -1);
  assign nb_d  = nb_of(data, cnt,  0,  1);
  assign nb_lu = nb_of(data, cnt, -1, -1);
  assign nb_ld = nb_of(data, cnt, -1,  1);
  assign nb_ru = nb_of(data, cnt,  1, -1);
  assign nb_rd = nb_of(data, cnt,  1,  1);

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] life_step(input logic [N-1:0] b);
    logic [N-1:0] r;
    int n;
    r = '0;
    for (int y = 0; y < Y; y++) begin
      for (int x = 0; x < X; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < X &&
                y + dy >= 0 && y + dy < Y)
              n += int'(b[(y + dy) * X + x + dx]);
          end
        end
        r[y * X + x] = (n == 3) || (b[y * X + x] && n == 2);
      end
    end
    return r;
  endfunction

  // Runs up to ngens (0 means 1) generations, cut short by stop_after (>0) or
  // by a generation equal to its predecessor.
  task automatic model_run(input logic [N-1:0] b0, input int ngens, input int stop_after,
                           output logic [N-1:0] bf, output int gens_done, output logic st);
    logic [N-1:0] b, nx;
    int target;
    b = b0;
    gens_done = 0;
    st = 1'b0;
    target = (ngens == 0) ? 1 : ngens;
    if (stop_after > 0 && stop_after < target) target = stop_after;
    while (gens_done < target) begin
      nx = life_step(b);
      gens_done++;
      st = (nx == b);
      b = nx;
      if (st) break;
    end
    bf = b;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_board(input logic [N-1:0] d);
    @(negedge clk);
    load = 1'b1;
    load_data = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns at the negedge following the edge that samples start (edge 0).
  task automatic start_run(input logic [GW-1:0] n);
    @(negedge clk);
    start = 1'b1;
    num_gens = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // k counts edges after edge 0; done seen after edge k means cycle k+1.
  task automatic wait_done(input string name, input int k0, input int budget, output int k);
    k = k0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: done not seen within %0d cycles", name, budget);
    end else begin
      check({name, " busy_with_done"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic run_and_check(input string name, input logic [N-1:0] init,
                               input logic [GW-1:0] ngens, input logic [N-1:0] exp_board,
                               input logic [GW-1:0] exp_gc, input logic exp_st,
                               input logic [CW:0] exp_pop, input int exp_cycles);
    int k;
    load_board(init);
    check({name, " load_pop"}, 64'(pop), 64'($countones(init)));
    check({name, " load_gc"}, 64'(gen_count), 64'd0);
    start_run(ngens);
    check({name, " busy"}, 64'(busy), 64'd1);
    wait_done(name, 0, exp_cycles + 20, k);
    check({name, " cycles"}, 64'(k + 1), 64'(exp_cycles));
    check({name, " board"}, board, exp_board);
    check({name, " gen_count"}, 64'(gen_count), 64'(exp_gc));
    check({name, " stable"}, 64'(stable), 64'(exp_st));
    check({name, " pop"}, 64'(pop), 64'(exp_pop));
    @(negedge clk);
    check({name, " done_pulse"}, 64'(done), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]  init;
    logic [GW-1:0] ngens;
    logic [N-1:0]  exp_board;
    logic [GW-1:0] exp_gc;
    logic          exp_st;
    logic [CW:0]   exp_pop;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [N-1:0] blinker_h, blinker_v, block, corners, glider, bf;
    int gd, k, seed_runs;
    logic st;

    rst = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    load_data = '0; num_gens = '0;
    tests = 0; fails = 0;

    // cell k = y*8+x
    blinker_h = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
    blinker_v = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
    block     = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9);
    corners   = (64'd1 << 0) | (64'd1 << 7) | (64'd1 << 56) | (64'd1 << 63);
    glider    = (64'd1 << 19) | (64'd1 << 28) | (64'd1 << 34) | (64'd1 << 35) | (64'd1 << 36);

    vecs[0] = '{blinker_h, 16'd1,  blinker_v, 16'd1, 1'b0, 7'd3, 66};
    vecs[1] = '{blinker_h, 16'd2,  blinker_h, 16'd2, 1'b0, 7'd3, 131};
    vecs[2] = '{block,     16'd10, block,     16'd1, 1'b1, 7'd4, 66};
    vecs[3] = '{corners,   16'd1,  64'd0,     16'd1, 1'b0, 7'd0, 66};
    vecs[4] = '{blinker_h, 16'd0,  blinker_v, 16'd1, 1'b0, 7'd3, 66};

    // ---- reset state ----
    do_reset();
    check("rst board", board, 64'd0);
    check("rst data", data, 64'd0);
    check("rst cnt", 64'(cnt), 64'd0);
    check("rst pop", 64'(pop), 64'd0);
    check("rst gen_count", 64'(gen_count), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst stable", 64'(stable), 64'd0);
    check("rst state", 64'(state), 64'd0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 5; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].init, vecs[i].ngens, vecs[i].exp_board,
                    vecs[i].exp_gc, vecs[i].exp_st, vecs[i].exp_pop, vecs[i].exp_cycles);
    end

    // ---- load and start together: load wins, start dropped ----
    @(negedge clk);
    load = 1'b1; start = 1'b1; load_data = glider; num_gens = 16'd1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    check("ldst board", board, glider);
    check("ldst busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("ldst still_idle", 64'(busy), 64'd0);

    // ---- stop during gen 2, with ignored load/start while busy ----
    model_run(glider, 5, 2, bf, gd, st);
    start_run(16'd5);
    repeat (10) @(negedge clk);
    load = 1'b1; load_data = '1; start = 1'b1; num_gens = 16'd1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    check("stop load_ignored", board, glider);
    check("stop busy", 64'(busy), 64'd1);
    repeat (84) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done("stop", 96, 400, k);
    check("stop cycles", 64'(k + 1), 64'(gd * GEN_CYCLES + 1));
    check("stop gen_count", 64'(gen_count), 64'(gd));
    check("stop board", board, bf);
    check("stop pop", 64'(pop), 64'($countones(bf)));

    // ---- reset in the middle of a scan ----
    load_board(blinker_h);
    start_run(16'd3);
    k = 0;
    while (cnt !== 6'd30 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("midrst reached_cnt30", 64'(cnt), 64'd30);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst board", board, 64'd0);
    check("midrst cnt", 64'(cnt), 64'd0);
    check("midrst pop", 64'(pop), 64'd0);
    check("midrst gen_count", 64'(gen_count), 64'd0);

    // ---- randomized boards against the model ----
    seed_runs = 12;
    for (int r = 0; r < seed_runs; r++) begin
      logic [N-1:0] init, expb;
      int ng;
      init = {$urandom, $urandom} & {$urandom, $urandom};
      if (r % 3 == 0) init = init & {$urandom, $urandom};
      ng = $urandom_range(0, 4);
      model_run(init, ng, 0, bf, gd, st);
      exp_q.push_back(bf);
      load_board(init);
      start_run(GW'(ng));
      wait_done($sformatf("rand%0d", r), 0, 5 * GEN_CYCLES + 20, k);
      expb = exp_q.pop_front();
      check($sformatf("rand%0d cycles", r), 64'(k + 1), 64'(gd * GEN_CYCLES + 1));
      check($sformatf("rand%0d board", r), board, expb);
      check($sformatf("rand%0d gen_count", r), 64'(gen_count), 64'(gd));
      check($sformatf("rand%0d stable", r), 64'(stable), 64'(st));
      check($sformatf("rand%0d pop", r), 64'(pop), 64'($countones(expb)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
